// File: rtl/pico_cyc10_qys_key.sv
// -----------------------------------------------------------------------------
// pico_cyc10_qys_key
//
// Debounced push-button peripheral with an Avalon-MM slave port. Each key pin
// is synchronized, debounced by a per-bit run-length counter, and a debounced
// press (1 -> 0) latches a sticky edgecapture bit. A mask register selects
// which captured edges raise the level interrupt.
//
// Register map (word address):
//   0  data         RO   debounced key state in bits WIDTH-1:0 (1 = released)
//   1  reserved     RO   reads 0
//   2  irqmask      RW   interrupt enable per key
//   3  edgecapture  R/W1C sticky press flags; writing 1 clears a bit
//
// Ports:
//   clk         system clock, all state on the rising edge
//   reset_n     asynchronous active-low reset
//   address     slave word address
//   chipselect  slave select
//   write_n     active-low write strobe, qualified by chipselect
//   writedata   write data; bits above WIDTH are ignored
//   in_port     asynchronous key pins, active-low
//   readdata    registered read data, valid one cycle after the access
//   irq         active-high level interrupt, |(edgecapture & irqmask)
// -----------------------------------------------------------------------------
module pico_cyc10_qys_key #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int CNT_W_RAW = $clog2(DEBOUNCE_CYCLES);
  localparam int CNT_W     = (CNT_W_RAW < 1) ? 1 : CNT_W_RAW;
  // Terminal count: the counter sits here on the cycle the change is accepted.
  localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] ADDR_DATA  = 2'd0;
  localparam logic [1:0] ADDR_RSVD  = 2'd1;
  localparam logic [1:0] ADDR_MASK  = 2'd2;
  localparam logic [1:0] ADDR_EDGE  = 2'd3;

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] stable_next;
  logic [CNT_W-1:0] cnt      [WIDTH];
  logic [CNT_W-1:0] cnt_next [WIDTH];

  logic [WIDTH-1:0] irqmask;
  logic [WIDTH-1:0] edgecapture;
  logic [WIDTH-1:0] edgecapture_next;
  logic [WIDTH-1:0] press;
  logic [WIDTH-1:0] clear_bits;

  logic             wr_en;
  logic             wr_mask;
  logic             wr_edge;
  logic [31:0]      read_mux;

  // ---------------------------------------------------------------------------
  // Two-flop synchronizer. Resets to "released" so the reset release itself
  // never looks like a key transition.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= in_port;
      sync2 <= sync1;
    end
  end

  // ---------------------------------------------------------------------------
  // Debounce: the counter measures how many consecutive cycles sync2 has
  // disagreed with the debounced state. Any agreement restarts it, so a glitch
  // shorter than DEBOUNCE_CYCLES never reaches the terminal count.
  // ---------------------------------------------------------------------------
  always_comb begin
    stable_next = stable;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_next[i] = '0;
      if (sync2[i] != stable[i]) begin
        if (cnt[i] == CNT_TC) begin
          stable_next[i] = sync2[i];
        end else begin
          cnt_next[i] = cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable <= '1;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      stable <= stable_next;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= cnt_next[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Bus write decode
  // ---------------------------------------------------------------------------
  assign wr_en   = chipselect && !write_n;
  assign wr_mask = wr_en && (address == ADDR_MASK);
  assign wr_edge = wr_en && (address == ADDR_EDGE);

  // A press is the debounced state falling this edge. Set is applied after
  // the clear so a simultaneous press and W1C leaves the bit set.
  assign press      = stable & ~stable_next;
  assign clear_bits = wr_edge ? writedata[WIDTH-1:0] : '0;

  always_comb begin
    edgecapture_next = (edgecapture & ~clear_bits) | press;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irqmask     <= '0;
      edgecapture <= '0;
    end else begin
      edgecapture <= edgecapture_next;
      if (wr_mask) begin
        irqmask <= writedata[WIDTH-1:0];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read path: sampled every cycle from the current (pre-write) register
  // contents, so a read concurrent with a write returns the old value.
  // ---------------------------------------------------------------------------
  always_comb begin
    read_mux = '0;
    case (address)
      ADDR_DATA: read_mux = {{(32-WIDTH){1'b0}}, stable};
      ADDR_RSVD: read_mux = '0;
      ADDR_MASK: read_mux = {{(32-WIDTH){1'b0}}, irqmask};
      ADDR_EDGE: read_mux = {{(32-WIDTH){1'b0}}, edgecapture};
      default:   read_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else begin
      readdata <= read_mux;
    end
  end

  // Registers only; no combinational path from the bus.
  assign irq = |(edgecapture & irqmask);

endmodule

// File: tb/tb_pico_cyc10_qys_key.sv
module tb_pico_cyc10_qys_key;

  localparam int W = 4;
  localparam int D = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic [1:0]    address = '0;
  logic          chipselect = 1'b0;
  logic          write_n = 1'b1;
  logic [31:0]   writedata = '0;
  logic [W-1:0]  in_port = '1;
  logic [31:0]   readdata;
  logic          irq;

  int n_checks = 0;
  int n_err    = 0;

  pico_cyc10_qys_key #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .in_port    (in_port),
    .readdata   (readdata),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_err);
    $fatal(1, "watchdog");
  end

  // Behavioural model: the synchronizer is a 2-deep delay line, the debounced
  // state flips when the last D synchronized samples all disagree with it.
  logic [W-1:0] m_pipe0, m_pipe1;
  logic [W-1:0] m_hist [D];
  logic [W-1:0] m_stable, m_ec, m_mask;
  logic [31:0]  m_rd;
  logic         m_rd_valid;

  task automatic model_reset();
    m_pipe0 = '1;
    m_pipe1 = '1;
    for (int j = 0; j < D; j++) m_hist[j] = '1;
    m_stable   = '1;
    m_ec       = '0;
    m_mask     = '0;
    m_rd       = '0;
    m_rd_valid = 1'b1;
  endtask

  task automatic model_step();
    logic [W-1:0] nst;
    logic [W-1:0] clr;
    logic         all_diff;
    for (int j = D-1; j > 0; j--) m_hist[j] = m_hist[j-1];
    m_hist[0] = m_pipe1;
    nst = m_stable;
    for (int i = 0; i < W; i++) begin
      all_diff = 1'b1;
      for (int j = 0; j < D; j++)
        if (m_hist[j][i] == m_stable[i]) all_diff = 1'b0;
      if (all_diff) nst[i] = ~m_stable[i];
    end
    case (address)
      2'd0:    m_rd = 32'(m_stable);
      2'd2:    m_rd = 32'(m_mask);
      2'd3:    m_rd = 32'(m_ec);
      default: m_rd = 32'd0;
    endcase
    m_rd_valid = chipselect;
    clr = (chipselect && !write_n && address == 2'd3) ? writedata[W-1:0] : '0;
    if (chipselect && !write_n && address == 2'd2) m_mask = writedata[W-1:0];
    m_ec     = (m_ec & ~clr) | (m_stable & ~nst);
    m_stable = nst;
    m_pipe1  = m_pipe0;
    m_pipe0  = in_port;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: advance the model with the inputs present at the edge, then
  // compare the DUT outputs 1 time unit later.
  task automatic cycle();
    @(posedge clk);
    if (reset_n) model_step();
    else model_reset();
    #1;
    if (m_rd_valid) chk("readdata", readdata, m_rd);
    chk("irq", 32'(irq), 32'(|(m_ec & m_mask)));
  endtask

  task automatic cycles(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic bus_idle();
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = 2'd0;
    writedata  = '0;
  endtask

  task automatic do_write(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    cycle();
    bus_idle();
  endtask

  task automatic do_read(input logic [1:0] a, output logic [31:0] v);
    chipselect = 1'b1;
    write_n    = 1'b1;
    address    = a;
    cycle();
    v = readdata;
    bus_idle();
  endtask

  // Poll address 0 each cycle; returns cycle index at which readdata first
  // equals target, and the cycle at which the model's state first did.
  task automatic watch_data(input logic [31:0] target, output int first, output int mfirst);
    first  = 0;
    mfirst = 0;
    chipselect = 1'b1;
    write_n    = 1'b1;
    address    = 2'd0;
    for (int k = 1; k <= 12; k++) begin
      cycle();
      if (first == 0 && readdata == target) first = k;
      if (mfirst == 0 && 32'(m_stable) == target) mfirst = k;
    end
    bus_idle();
  endtask

  initial begin
    logic [31:0] v;
    int first, mfirst;

    bus_idle();
    in_port = '1;
    #2;
    reset_n = 1'b0;
    model_reset();
    cycles(3);
    reset_n = 1'b1;
    cycles(2);

    // Reset state
    do_read(2'd0, v); chk("reset_data", v, 32'h0000000F);
    do_read(2'd2, v); chk("reset_mask", v, 32'h0);
    do_read(2'd3, v); chk("reset_edge", v, 32'h0);
    chk("reset_irq", 32'(irq), 32'h0);

    // Glitch of 3 cycles on key 1
    in_port[1] = 1'b0;
    cycles(3);
    in_port[1] = 1'b1;
    cycles(8);
    do_read(2'd0, v); chk("glitch_data", v, 32'h0000000F);
    do_read(2'd3, v); chk("glitch_edge", v, 32'h0);

    // Press latency on key 0: state falls at edge 6, visible on readdata at 7
    in_port[0] = 1'b0;
    watch_data(32'hE, first, mfirst);
    chk("press_latency_dut", 32'(first), 32'd7);
    chk("press_latency_model", 32'(mfirst), 32'd6);
    do_read(2'd3, v); chk("press_edge", v, 32'h1);
    do_read(2'd0, v); chk("press_data", v, 32'hE);

    // Release of key 0
    in_port[0] = 1'b1;
    watch_data(32'hF, first, mfirst);
    chk("release_latency_dut", 32'(first), 32'd7);
    do_read(2'd3, v); chk("release_edge", v, 32'h1);

    // Interrupt
    do_write(2'd3, 32'hFFFF_FFFF);
    do_write(2'd2, 32'h1);
    do_read(2'd2, v); chk("mask_readback", v, 32'h1);
    chk("irq_idle", 32'(irq), 32'h0);
    in_port[0] = 1'b0;
    first = 0;
    for (int k = 1; k <= 12; k++) begin
      cycle();
      if (first == 0 && irq) first = k;
    end
    chk("irq_rise_cycle", 32'(first), 32'd6);
    do_write(2'd3, 32'h1);
    chk("irq_clear", 32'(irq), 32'h0);
    in_port[0] = 1'b1;
    cycles(10);
    in_port[2] = 1'b0;
    cycles(10);
    do_read(2'd3, v); chk("key2_edge", v, 32'h4);
    chk("key2_irq_masked", 32'(irq), 32'h0);
    in_port[2] = 1'b1;
    cycles(10);
    do_write(2'd3, 32'hF);

    // Set wins over a concurrent write-1-to-clear
    in_port[0] = 1'b0;
    cycles(5);
    do_write(2'd3, 32'h1);
    do_read(2'd3, v); chk("set_wins", v, 32'h1);
    in_port[0] = 1'b1;
    cycles(10);
    do_write(2'd3, 32'hF);

    // Reset mid-debounce: pending change discarded, full latency after release
    in_port[0] = 1'b0;
    cycles(4);
    reset_n = 1'b0;
    model_reset();
    cycles(2);
    chk("mid_reset_irq", 32'(irq), 32'h0);
    reset_n = 1'b1;
    watch_data(32'hE, first, mfirst);
    chk("post_reset_latency", 32'(first), 32'd7);
    do_read(2'd3, v); chk("post_reset_edge", v, 32'h1);
    in_port[0] = 1'b1;
    cycles(10);
    do_write(2'd3, 32'hF);

    // Randomized traffic against the model
    for (int n = 0; n < 4000; n++) begin
      for (int i = 0; i < W; i++)
        if ($urandom_range(0, 5) == 0) in_port[i] = ~in_port[i];
      chipselect = 1'($urandom_range(0, 1));
      write_n    = ($urandom_range(0, 2) != 0);
      address    = 2'($urandom_range(0, 3));
      writedata  = $urandom();
      if ($urandom_range(0, 999) == 0) begin
        reset_n = 1'b0;
        model_reset();
        cycle();
        reset_n = 1'b1;
      end else begin
        cycle();
      end
    end
    bus_idle();
    cycles(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
